// File: rtl/dpram_arb.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Optional power-on RAM clear when DPRAM_ARB_CLEAR_EN is defined.
module dpram_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_rvalid,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    logic              last_b;
    logic              rd_pend;
    logic              rd_tag;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_act;
    logic              run;

`ifdef DPRAM_ARB_CLEAR_EN
    typedef enum logic {CLEAR, RUN} state_t;
    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == '1) begin
                state <= RUN;
                busy  <= 1'b0;
            end
        end
    end

    assign clearing = (state == CLEAR);
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
    assign busy     = 1'b0;
`endif

    // reset gates everything combinational so nothing leaks out mid-reset
    assign clr_act = clearing & ~rst;
    assign run     = ~clearing & ~rst;

    assign a_gnt = run & a_req & (~b_req | last_b);
    assign b_gnt = run & b_req & (~a_req | ~last_b);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        unique case (1'b1)
            clr_act: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = clr_addr;
            end
            a_gnt: begin
                ram_en    = 1'b1;
                ram_we    = a_we;
                ram_addr  = a_addr;
                ram_wdata = a_wdata;
            end
            b_gnt: begin
                ram_en    = 1'b1;
                ram_we    = b_we;
                ram_addr  = b_addr;
                ram_wdata = b_wdata;
            end
            default: ;
        endcase
    end

    // one-deep read pipeline; rd_tag says which side owns the returning data
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b  <= 1'b1;
            rd_pend <= 1'b0;
            rd_tag  <= 1'b0;
        end else begin
            rd_pend <= (a_gnt & ~a_we) | (b_gnt & ~b_we);
            rd_tag  <= b_gnt;
            if (a_gnt)
                last_b <= 1'b0;
            else if (b_gnt)
                last_b <= 1'b1;
        end
    end

    assign a_rvalid = ~rst & rd_pend & ~rd_tag;
    assign b_rvalid = ~rst & rd_pend & rd_tag;
    assign a_rdata  = a_rvalid ? ram_rdata : '0;
    assign b_rdata  = b_rvalid ? ram_rdata : '0;

endmodule
